fetcher: RTL
============

# fetcher

Instruction-fetch stage of the RISC-V pipeline, the producer of the IF/ID pipeline record (valid, inst, inst_pc, inst_counter) that the decode stage consumes. It owns the program counter and drives a single-outstanding-request instruction bus. It buffers one returned instruction when decode stalls. It applies redirects (branch, jump, trap) from later stages and discards any in-flight fetch those redirects make stale.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, address of the first fetch after reset
- XLEN, 64, PC and counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  out  1  instruction request outstanding
- ireq_addr  out  XLEN  fetch address, 4-byte aligned
- iresp_data_ok  in  1  response valid for the current request
- iresp_data  in  32  returned instruction word
- stall  in  1  decode not accepting; IF/ID record must hold
- redirect_valid  in  1  flush and refetch from redirect_pc
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0
- if_id_valid  out  1  IF/ID record carries a live instruction
- if_id_inst  out  32  instruction word
- if_id_inst_pc  out  XLEN  PC of if_id_inst
- if_id_inst_counter  out  XLEN  sequence number of the delivered instruction

## Operation
- Internal state: pc, saved target (tgt), one-entry skid buffer (buf_inst, buf_pc), delivery counter cnt, FSM.
- FSM states:
  - IDLE: reset state.
  - FETCH: request outstanding at pc.
  - HOLD: instruction captured in the skid buffer, no request outstanding.
  - DRAIN: stale request outstanding; its response is discarded, then fetch resumes at tgt.
- ireq_valid = (state==FETCH || state==DRAIN).
- ireq_addr = pc.
- Bus rule: ireq_addr is stable from assertion of ireq_valid until the cycle iresp_data_ok=1. The request completes in that cycle.
- Redirect has priority over every other event in every state:
  - if_id_valid <= 0, regardless of stall.
  - Skid buffer invalidated.
- Transitions:
  - IDLE: next state FETCH; pc = redirect_valid ? redirect_pc : RESET_PC.
  - FETCH, redirect, data_ok=1: data dropped; pc <= redirect_pc; stay in FETCH.
  - FETCH, redirect, data_ok=0: tgt <= redirect_pc; next state DRAIN.
  - FETCH, data_ok=1, !stall: deliver the response; pc <= pc+4; stay in FETCH.
  - FETCH, data_ok=1, stall: buf <= (iresp_data, pc); pc <= pc+4; next state HOLD.
  - FETCH, data_ok=0, !stall: if_id_valid <= 0 (bubble).
  - HOLD, !stall: deliver the buffer; next state FETCH.
  - HOLD, redirect: pc <= redirect_pc; next state FETCH.
  - DRAIN, redirect: tgt overwritten; stay in DRAIN.
  - DRAIN, data_ok=1: data dropped; pc <= tgt; next state FETCH.
  - DRAIN, data_ok=0: stay in DRAIN.
  - DRAIN, !stall: if_id_valid <= 0.
- Deliver means:
  - if_id_valid <= 1.
  - if_id_inst and if_id_inst_pc loaded.
  - if_id_inst_counter <= cnt.
  - cnt <= cnt+1.
- Whenever stall=1 and no redirect, all if_id_* registers hold.
- cnt wraps modulo 2^XLEN. cnt is not altered by redirects.
- pc+4 wraps modulo 2^XLEN.

## Timing
- Reset (asynchronous, immediate): state=IDLE, pc=RESET_PC, cnt=0, tgt=0, buffer empty; all if_id_* = 0; ireq_valid=0; ireq_addr=RESET_PC.
- Reset asserted mid-request: the request is abandoned with no wait for data_ok. Any late data_ok is ignored in IDLE.
- First ireq_valid=1 occurs 1 cycle after reset deasserts.
- Latency: data_ok in cycle N with !stall gives if_id_valid=1 in N+1.
- The next request (pc+4) is visible in N+1, so throughput is 1 instruction/cycle with same-cycle data_ok.
- Stall released in cycle M while in HOLD: the buffered instruction appears on IF/ID in M+1, and the next request is issued in M+1.
- Redirect in cycle R: if_id_valid=0 in R+1.
- Redirect in FETCH with data_ok in R: request to the target in R+1.
- Redirect in FETCH without data_ok in R: request to the target in the cycle after the stale data_ok.
- Instructions from stale fetches are never delivered.
- if_id_inst_counter is strictly consecutive across all delivered instructions.

## Test plan
- Reset release, memory answers data_ok same cycle with 0x00000013 at every address:
  - first ireq_addr=0x80000000 one cycle after release;
  - IF/ID shows pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles;
  - counters 0,1,2.
- stall held 3 cycles while data_ok returns inst 0x00a00093 at 0x80000004:
  - ireq_valid=0 during HOLD;
  - IF/ID unchanged;
  - after release, IF/ID = (0x00a00093, 0x80000004) one cycle later, then fetch 0x80000008.
- Memory latency 3 cycles; redirect to 0x80001002 one cycle after a request to 0x80000010:
  - ireq_addr stays 0x80000010 until data_ok;
  - that data is not delivered;
  - next request is 0x80001000.
- Redirect in the same cycle as data_ok with stall=1:
  - if_id_valid=0 next cycle despite stall;
  - next request at the target;
  - counter not incremented.
- Second redirect (0x80002000) during DRAIN after a first redirect (0x80001000): after the stale data_ok, the fetch goes to 0x80002000 only.
- Reset asserted while a request is outstanding and in HOLD:
  - all outputs return to reset values immediately;
  - a data_ok arriving during IDLE has no effect.

Source files
------------

// File: rtl/fetcher.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding instruction bus,
// skid-buffers one response under decode stall and squashes stale fetches on redirect.
module fetcher #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_inst,
    output logic [XLEN-1:0] if_id_inst_pc,
    output logic [XLEN-1:0] if_id_inst_counter
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] tgt, tgt_next;
    logic [XLEN-1:0] cnt;
    logic [31:0]     buf_inst;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] redir_pc;
    logic            capture;
    logic            deliver;
    logic            deliver_buf;
    logic            bubble;

    assign ireq_valid = (state == FETCH) || (state == DRAIN);
    assign ireq_addr  = pc;
    assign redir_pc   = redirect_pc & ~XLEN'(3);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        tgt_next    = tgt;
        capture     = 1'b0;
        deliver     = 1'b0;
        deliver_buf = 1'b0;
        bubble      = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                pc_next    = redirect_valid ? redir_pc : RESET_PC;
                bubble     = redirect_valid;
            end
            FETCH: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
                    if (iresp_data_ok) begin
                        pc_next = redir_pc;
                    end else begin
                        tgt_next   = redir_pc;
                        state_next = DRAIN;
                    end
                end else if (iresp_data_ok) begin
                    pc_next = pc + XLEN'(4);
                    if (stall) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    bubble     = 1'b1;
                    pc_next    = redir_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    deliver     = 1'b1;
                    deliver_buf = 1'b1;
                    state_next  = FETCH;
                end
            end
            DRAIN: begin
                // The stale request must still complete on the bus before fetching the target.
                if (redirect_valid) begin
                    bubble   = 1'b1;
                    tgt_next = redir_pc;
                end else begin
                    if (iresp_data_ok) begin
                        pc_next    = tgt;
                        state_next = FETCH;
                    end
                    bubble = !stall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the skid buffer is reset with everything else; it is two registers, not a memory array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                 <= RESET_PC;
            tgt                <= '0;
            cnt                <= '0;
            buf_inst           <= '0;
            buf_pc             <= '0;
            if_id_valid        <= 1'b0;
            if_id_inst         <= '0;
            if_id_inst_pc      <= '0;
            if_id_inst_counter <= '0;
        end else begin
            pc  <= pc_next;
            tgt <= tgt_next;
            if (capture) begin
                buf_inst <= iresp_data;
                buf_pc   <= pc;
            end
            if (deliver) begin
                if_id_valid        <= 1'b1;
                if_id_inst         <= deliver_buf ? buf_inst : iresp_data;
                if_id_inst_pc      <= deliver_buf ? buf_pc : pc;
                if_id_inst_counter <= cnt;
                cnt                <= cnt + XLEN'(1);
            end else if (bubble) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule
